// File: rtl/ghash_pkg.sv
// ---------------------------------------------------------------------------
// ghash_pkg
// Shared definitions for the GHASH sequencer and its GF(2^128) multiplier.
//   NB_DATA        : GHASH block width (128)
//   R_X            : GCM reduction constant, 0xE1 || 0^120 (GCM reflected bit order)
//   state_t        : sequencer FSM encoding
//   pack_len_block : builds the {len(A), len(C)} block from the two bit counters
// ---------------------------------------------------------------------------
package ghash_pkg;

    localparam int NB_DATA = 128;
    localparam logic [NB_DATA-1:0] R_X = {8'hE1, 120'h0};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WAIT   = 3'd2,
        ST_LEN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // 64-bit AAD bit length in the upper half, 64-bit text bit length in the lower half.
    function automatic logic [NB_DATA-1:0] pack_len_block(input logic [63:0] len_aad,
                                                          input logic [63:0] len_txt);
        return {len_aad, len_txt};
    endfunction

endpackage

// File: rtl/gf_2to128_mult_pipe.sv
// ---------------------------------------------------------------------------
// gf_2to128_mult_pipe
// Combinational GF(2^128) multiplier (GCM bit order: MSB of the block is the
// x^0 coefficient) followed by N_PIPE output register stages with a valid bit.
// Ports:
//   i_clock    : clock, rising edge
//   i_reset_n  : asynchronous active-low reset
//   i_flush    : clears every stage (data and valid); wins over i_valid
//   i_valid    : launch a product of i_a * i_b this cycle
//   i_a, i_b   : operands
//   o_valid    : product available (N_PIPE cycles after launch)
//   o_product  : registered product
// ---------------------------------------------------------------------------
module gf_2to128_mult_pipe
    import ghash_pkg::*;
#(
    parameter int N_PIPE = 1
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_product
);

    // Right-shift algorithm: walk the bits of x from the x^0 end (MSB) and
    // multiply v by x each step, folding the overflow back in with R_X.
    function automatic logic [NB_DATA-1:0] gf_mult(input logic [NB_DATA-1:0] x,
                                                   input logic [NB_DATA-1:0] y);
        logic [NB_DATA-1:0] z;
        logic [NB_DATA-1:0] v;
        logic [NB_DATA-1:0] xs;
        z  = '0;
        v  = y;
        xs = x;
        for (int i = 0; i < NB_DATA; i++) begin
            if (xs[NB_DATA-1]) begin
                z = z ^ v;
            end
            xs = xs << 1;
            v  = v[0] ? ((v >> 1) ^ R_X) : (v >> 1);
        end
        return z;
    endfunction

    logic [NB_DATA-1:0] product_comb;

    always_comb begin
        product_comb = gf_mult(i_a, i_b);
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_PIPE; gi++) begin : g_stage
            logic [NB_DATA-1:0] d_in;
            logic               v_in;
            logic [NB_DATA-1:0] data_reg;
            logic               valid_reg;

            if (gi == 0) begin : g_head
                assign d_in = product_comb;
                assign v_in = i_valid;
            end else begin : g_link
                assign d_in = g_stage[gi-1].data_reg;
                assign v_in = g_stage[gi-1].valid_reg;
            end

            always_ff @(posedge i_clock or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (i_flush) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    data_reg  <= d_in;
                    valid_reg <= v_in;
                end
            end
        end
    endgenerate

    assign o_product = g_stage[N_PIPE-1].data_reg;
    assign o_valid   = g_stage[N_PIPE-1].valid_reg;

endmodule

// File: rtl/ghash_sequencer.sv
// ---------------------------------------------------------------------------
// ghash_sequencer
// Runs GHASH over a block stream: Y <= (Y ^ X_i) * H through a registered
// multiplier, and emits the final Y once per message.
// Optional feature macro: GHASH_LEN_BLOCK_EN
//   defined   : AAD/text bit-length counters kept, {len(A),len(C)} block
//               appended internally after the i_last block (LEN state).
//   undefined : caller sends the length block itself as the i_last block;
//               i_is_aad / i_nbytes are ignored.
// Ports:
//   i_clock, i_reset_n   : clock (rising edge), asynchronous active-low reset
//   i_start              : abort/clear, load H from i_h_key, go accept blocks
//   i_h_key              : hash subkey H
//   i_data, i_valid      : block X_i and its valid (accepted when o_ready=1)
//   i_is_aad, i_nbytes   : block class and valid byte count (0 means 16)
//   i_last               : last block; with i_valid=0 in ACCEPT it closes
//                          the message without a further data block
//   o_ready              : can accept a block this cycle
//   o_busy               : message in progress
//   o_ghash, o_ghash_valid : final GHASH value and its 1-cycle update pulse
// A NB_DATA other than 128 or N_PIPE outside 1..4 is an unsupported
// configuration: the block then never raises o_ready.
// ---------------------------------------------------------------------------
module ghash_sequencer #(
    parameter int NB_DATA = 128,
    parameter int N_PIPE  = 1,
    parameter int NB_LEN  = 64
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_h_key,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    input  logic               i_is_aad,
    input  logic [4:0]         i_nbytes,
    input  logic               i_last,
    output logic               o_ready,
    output logic               o_busy,
    output logic [NB_DATA-1:0] o_ghash,
    output logic               o_ghash_valid
);
    import ghash_pkg::*;

    localparam int GW       = ghash_pkg::NB_DATA;
    localparam bit BAD_CONF = (NB_DATA != GW) || (N_PIPE < 1) || (N_PIPE > 4);

    state_t          state_reg, state_next;
    logic [GW-1:0]   y_reg, h_reg, ghash_reg;
    logic            ghash_valid_reg;
    logic            last_reg;       // block in flight carried i_last
    logic            len_phase_reg;  // block in flight is the length block
    logic [GW-1:0]   data_w;
    logic [GW-1:0]   mult_a, mult_product, tag_value;
    logic            mult_launch, mult_valid, accept, y_load, tag_load;

    assign data_w = GW'(i_data);

`ifdef GHASH_LEN_BLOCK_EN
    logic [NB_LEN-1:0] len_aad_reg, len_txt_reg, len_incr;
    logic [NB_LEN:0]   aad_sum, txt_sum;
    logic [4:0]        nbytes_eff;
    logic [GW-1:0]     len_block;

    always_comb begin
        nbytes_eff = ((i_nbytes == 5'd0) || (i_nbytes > 5'd16)) ? 5'd16 : i_nbytes;
        len_incr   = NB_LEN'({nbytes_eff, 3'b000});
        aad_sum    = {1'b0, len_aad_reg} + {1'b0, len_incr};
        txt_sum    = {1'b0, len_txt_reg} + {1'b0, len_incr};
    end

    assign len_block = pack_len_block(64'(len_aad_reg), 64'(len_txt_reg));

    // Bit counters saturate at all-ones instead of wrapping.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            len_aad_reg <= '0;
            len_txt_reg <= '0;
        end else if (i_start) begin
            len_aad_reg <= '0;
            len_txt_reg <= '0;
        end else if (accept) begin
            if (i_is_aad) begin
                len_aad_reg <= aad_sum[NB_LEN] ? '1 : aad_sum[NB_LEN-1:0];
            end else begin
                len_txt_reg <= txt_sum[NB_LEN] ? '1 : txt_sum[NB_LEN-1:0];
            end
        end
    end
`else
    logic unused_len_inputs;
    assign unused_len_inputs = ^{i_is_aad, i_nbytes, (NB_LEN > 0)};
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        o_ready     = (state_reg == ST_ACCEPT) && !BAD_CONF;
        mult_a      = y_reg ^ data_w;
        mult_launch = 1'b0;
        accept      = 1'b0;
        y_load      = 1'b0;
        tag_load    = 1'b0;
        tag_value   = mult_product;
        if (i_start) begin
            // Start overrides everything, including a simultaneous i_valid.
            state_next = ST_ACCEPT;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_IDLE;
                end
                ST_ACCEPT: begin
                    if (i_valid && o_ready) begin
                        accept      = 1'b1;
                        mult_launch = 1'b1;
                        state_next  = ST_WAIT;
                    end else if (i_last && !BAD_CONF) begin
                        // Message closed with no further data block.
`ifdef GHASH_LEN_BLOCK_EN
                        state_next = ST_LEN;
`else
                        state_next = ST_DONE;
                        tag_load   = 1'b1;
                        tag_value  = y_reg;
`endif
                    end
                end
                ST_WAIT: begin
                    if (mult_valid) begin
                        y_load = 1'b1;
`ifdef GHASH_LEN_BLOCK_EN
                        if (len_phase_reg) begin
                            state_next = ST_DONE;
                            tag_load   = 1'b1;
                        end else if (last_reg) begin
                            state_next = ST_LEN;
                        end else begin
                            state_next = ST_ACCEPT;
                        end
`else
                        if (last_reg) begin
                            state_next = ST_DONE;
                            tag_load   = 1'b1;
                        end else begin
                            state_next = ST_ACCEPT;
                        end
`endif
                    end
                end
`ifdef GHASH_LEN_BLOCK_EN
                ST_LEN: begin
                    mult_a      = y_reg ^ len_block;
                    mult_launch = 1'b1;
                    state_next  = ST_WAIT;
                end
`endif
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // The tag register is loaded on the edge that enters DONE, so the pulse
    // and the new value are visible together during the DONE cycle.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            y_reg           <= '0;
            h_reg           <= '0;
            last_reg        <= 1'b0;
            len_phase_reg   <= 1'b0;
            ghash_reg       <= '0;
            ghash_valid_reg <= 1'b0;
        end else begin
            ghash_valid_reg <= 1'b0;
            if (i_start) begin
                y_reg         <= '0;
                h_reg         <= GW'(i_h_key);
                last_reg      <= 1'b0;
                len_phase_reg <= 1'b0;
            end else begin
                if (mult_launch) begin
                    last_reg      <= accept ? i_last : 1'b1;
                    len_phase_reg <= (state_reg == ST_LEN);
                end
                if (y_load) begin
                    y_reg <= mult_product;
                end
                if (tag_load) begin
                    ghash_reg       <= tag_value;
                    ghash_valid_reg <= 1'b1;
                end
            end
        end
    end

    gf_2to128_mult_pipe #(
        .N_PIPE (N_PIPE)
    ) u_mult (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_flush   (i_start),
        .i_valid   (mult_launch),
        .i_a       (mult_a),
        .i_b       (h_reg),
        .o_valid   (mult_valid),
        .o_product (mult_product)
    );

    assign o_busy        = (state_reg != ST_IDLE);
    assign o_ghash       = NB_DATA'(ghash_reg);
    assign o_ghash_valid = ghash_valid_reg;

endmodule
